// File: rtl/i2s_receive.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receive
// Purpose  : Oversampled Philips I2S receiver. Synchronises BCLK/LRCLK/SDATA
//            into the clk domain, deserialises MSB-first words (MSB one BCLK
//            after the LRCLK edge), qualifies the frame by slot length and
//            presents left/right as a coherent pair for an SPDIF transmitter.
// Ports    : clk, rst          - system clock, synchronous active-high reset
//            i2s_bclk/lrclk/sdata - asynchronous I2S inputs
//            data_left/right   - {zero pad, DATA_W-bit word}
//            sample_valid      - one-clk strobe, new pair presented
//            validity          - SPDIF V bit (1 = not locked)
//            locked            - frame lock status
// Revision : 1.0 - initial release
// ============================================================================
module i2s_receive #(
    parameter int DATA_W   = 24,
    parameter int MIN_SLOT = 16,
    parameter int MAX_SLOT = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2s_bclk,
    input  logic        i2s_lrclk,
    input  logic        i2s_sdata,
    output logic [31:0] data_left,
    output logic [31:0] data_right,
    output logic        sample_valid,
    output logic        validity,
    output logic        locked
);

    localparam int                c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX  = c_TO_W'(TIMEOUT);
    localparam logic [5:0]        c_DW6     = 6'(DATA_W);
    localparam logic [5:0]        c_DW_M1   = 6'(DATA_W - 1);
    localparam logic [5:0]        c_MIN6    = 6'(MIN_SLOT);
    localparam logic [5:0]        c_MAX6    = 6'(MAX_SLOT);

    localparam logic [1:0] c_ST_SEARCH  = 2'd0;
    localparam logic [1:0] c_ST_MEASURE = 2'd1;
    localparam logic [1:0] c_ST_VERIFY  = 2'd2;
    localparam logic [1:0] c_ST_LOCKED  = 2'd3;

    // synchronisers; the third bclk stage only serves edge detection
    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lr_s1, r_lr_s2, r_sd_s1, r_sd_s2;
    logic r_lr_d;

    logic [5:0]        r_bit_cnt;
    logic [c_TO_W-1:0] r_idle_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_left_pend;
    logic              r_left_ok;
    logic              r_emit;
    logic [1:0]        r_state;
    logic [5:0]        r_slot_len;

    logic              w_bclk_re;
    logic              w_boundary;
    logic              w_done_left;
    logic              w_done_right;
    logic              w_timeout;
    logic [5:0]        w_k;
    logic [5:0]        w_idx;
    logic              w_capture;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_shreg_next;
    logic              w_in_range;
    logic              w_match_locked;
    logic [1:0]        w_state_next;
    logic [5:0]        w_slot_len_next;

    assign w_bclk_re    = r_bclk_s2 & ~r_bclk_s3;
    assign w_boundary   = w_bclk_re & (r_lr_s2 != r_lr_d);
    // the LSB edge closes the word of the channel that was active before it
    assign w_done_left  = w_boundary & ~r_lr_d;
    assign w_done_right = w_boundary &  r_lr_d;
    assign w_timeout    = ~w_bclk_re & (r_idle_cnt == c_TO_LAST);

    // bit index within the current word; bit_cnt==0 means position unknown
    assign w_k       = r_bit_cnt - 6'd1;
    assign w_idx     = c_DW_M1 - w_k;
    assign w_capture = w_bclk_re & (r_bit_cnt != 6'd0) & (w_k < c_DW6);
    assign w_mask    = {{(DATA_W-1){1'b0}}, 1'b1} << w_idx;

    // the slot length is the bit count including the boundary edge itself
    assign w_in_range     = (r_bit_cnt >= c_MIN6) && (r_bit_cnt <= c_MAX6);
    assign w_match_locked = (r_state == c_ST_LOCKED) && (r_bit_cnt == r_slot_len);

    always_comb begin
        w_shreg_next = r_shreg;
        if (w_capture) begin
            // MSB position starts a fresh word so short slots pad with zeros
            w_shreg_next = ((w_k == 6'd0) ? '0 : r_shreg) | (r_sd_s2 ? w_mask : '0);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_slot_len_next = r_slot_len;
        if (w_timeout) begin
            w_state_next = c_ST_SEARCH;
        end else if (w_boundary) begin
            case (r_state)
                c_ST_SEARCH: w_state_next = c_ST_MEASURE;
                c_ST_MEASURE: begin
                    if (w_in_range) begin
                        w_slot_len_next = r_bit_cnt;
                        w_state_next    = c_ST_VERIFY;
                    end
                end
                c_ST_VERIFY: begin
                    if (r_bit_cnt == r_slot_len) begin
                        w_state_next = c_ST_LOCKED;
                    end else if (w_in_range) begin
                        w_slot_len_next = r_bit_cnt;
                    end else begin
                        w_state_next = c_ST_MEASURE;
                    end
                end
                default: begin
                    if (r_bit_cnt != r_slot_len) w_state_next = c_ST_MEASURE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_SEARCH;
            r_slot_len <= '0;
            locked     <= 1'b0;
            validity   <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_slot_len <= w_slot_len_next;
            locked     <= (w_state_next == c_ST_LOCKED);
            validity   <= (w_state_next != c_ST_LOCKED);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_s1    <= 1'b0;
            r_bclk_s2    <= 1'b0;
            r_bclk_s3    <= 1'b0;
            r_lr_s1      <= 1'b0;
            r_lr_s2      <= 1'b0;
            r_sd_s1      <= 1'b0;
            r_sd_s2      <= 1'b0;
            r_lr_d       <= 1'b0;
            r_bit_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_shreg      <= '0;
            r_left_pend  <= '0;
            r_left_ok    <= 1'b0;
            r_emit       <= 1'b0;
            data_left    <= '0;
            data_right   <= '0;
            sample_valid <= 1'b0;
        end else begin
            r_bclk_s1 <= i2s_bclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_s3 <= r_bclk_s2;
            r_lr_s1   <= i2s_lrclk;
            r_lr_s2   <= r_lr_s1;
            r_sd_s1   <= i2s_sdata;
            r_sd_s2   <= r_sd_s1;

            if (w_bclk_re) begin
                r_lr_d <= r_lr_s2;
                if (w_boundary)               r_bit_cnt <= 6'd1;
                else if (r_bit_cnt != 6'd63)  r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if (w_bclk_re)                  r_idle_cnt <= '0;
            else if (r_idle_cnt != c_TO_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;

            r_shreg <= w_shreg_next;

            // a left word only pairs up if it was taken while already locked
            if (w_done_left) begin
                r_left_pend <= w_shreg_next;
                r_left_ok   <= w_match_locked;
            end else if (w_done_right) begin
                r_left_ok <= 1'b0;
            end

            // right LSB lands in shreg this clk; publish the pair on the next
            r_emit       <= w_done_right & w_match_locked & r_left_ok;
            sample_valid <= r_emit;
            if (r_emit) begin
                data_left  <= 32'(r_left_pend);
                data_right <= 32'(r_shreg);
            end

            if (w_timeout) begin
                r_bit_cnt   <= '0;
                r_shreg     <= '0;
                r_left_pend <= '0;
                r_left_ok   <= 1'b0;
                r_emit      <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
